// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI word receiver.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PUSH = 2'd2
  } rx_state_e;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  // Drop a completed byte into its little-endian lane of the word being assembled.
  function automatic logic [WORD_W-1:0] put_lane(input logic [WORD_W-1:0] word,
                                                 input logic [BYTE_W-1:0] data,
                                                 input logic [1:0]        lane);
    logic [WORD_W-1:0] res;
    res = word;
    case (lane)
      2'd0:    res[7:0]   = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[23:16] = data;
      2'd3:    res[31:24] = data;
      default: res        = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous word FIFO with wrap-bit pointers and registered full/empty flags.
module spi_rx_fifo #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              rd_acc;
  logic              wr_acc;

  // A pop while full frees the slot the simultaneous push lands in.
  always_comb begin
    rd_acc   = rd_en_i && !empty_q;
    wr_acc   = wr_en_i && (!full_q || rd_acc);
    wr_ptr_d = wr_acc ? (wr_ptr_q + {{PTR_W{1'b0}}, 1'b1}) : wr_ptr_q;
    rd_ptr_d = rd_acc ? (rd_ptr_q + {{PTR_W{1'b0}}, 1'b1}) : rd_ptr_q;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
               (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/spi_word_rx.sv
// SPI mode-0 slave receiver: bytes MSB-first, packed little-endian into 32-bit words, FIFO buffered.
// Optional SPI_RX_WORD_CNT_EN adds word_cnt_o, a saturating count of words accepted into the FIFO.
module spi_word_rx
  import spi_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_sys_i,
  input  logic              rst_sys_ni,
  input  logic              sck_i,
  input  logic              mosi_i,
  input  logic              ss_ni,
  input  logic              rd_en_i,
  output logic [WORD_W-1:0] data_o,
  output logic              rx_ack_o,
  output logic              empty_o,
  output logic              ss_o,
  output logic              overflow_o,
  output logic              frame_err_o
`ifdef SPI_RX_WORD_CNT_EN
  ,
  output logic [15:0]       word_cnt_o
`endif
);

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic                   sck_prev_q;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   ss_s;
  logic                   sck_rise;

  rx_state_e              state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0]      shift_q, shift_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic [BYTE_W-1:0]      byte_next;
  logic                   push;
  logic                   frame_err_d;

  logic [WORD_W-1:0]      fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   push_ok;
  logic                   push_drop;

  logic [WORD_W-1:0]      data_q;
  logic                   rx_ack_q;
  logic                   overflow_q;
  logic                   frame_err_q;

  // SS resets to the deselected level so a reset never looks like a frame start.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_ni};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s && !sck_prev_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    word_d      = word_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    byte_next   = {shift_q[BYTE_W-2:0], mosi_s};
    case (state_q)
      IDLE: begin
        bit_cnt_d  = 3'd0;
        byte_cnt_d = 2'd0;
        shift_d    = '0;
        word_d     = '0;
        if (!ss_s) begin
          state_d = RECV;
        end else begin
          state_d = IDLE;
        end
      end
      RECV: begin
        if (ss_s) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != 3'd0) || (byte_cnt_q != 2'd0);
          bit_cnt_d   = 3'd0;
          byte_cnt_d  = 2'd0;
          shift_d     = '0;
          word_d      = '0;
        end else if (sck_rise) begin
          shift_d = byte_next;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            word_d    = put_lane(word_q, byte_next, byte_cnt_q);
            if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
              byte_cnt_d = 2'd0;
              state_d    = PUSH;
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = RECV;
        end
      end
      PUSH: begin
        push   = 1'b1;
        word_d = '0;
        if (ss_s) begin
          state_d = IDLE;
        end else begin
          state_d = RECV;
        end
      end
      default: begin
        state_d    = IDLE;
        bit_cnt_d  = 3'd0;
        byte_cnt_d = 2'd0;
        shift_d    = '0;
        word_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 2'd0;
      shift_q    <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
    end
  end

  // A pop in the same cycle as a push into a full FIFO makes room for it.
  assign pop       = rd_en_i && !fifo_empty;
  assign push_ok   = push && (!fifo_full || pop);
  assign push_drop = push && fifo_full && !pop;

  spi_rx_fifo #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_sys_i),
    .rst_ni    (rst_sys_ni),
    .wr_en_i   (push),
    .wr_data_i (word_q),
    .rd_en_i   (rd_en_i),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      data_q      <= '0;
      rx_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      data_q      <= pop ? fifo_rdata : data_q;
      rx_ack_q    <= pop;
      overflow_q  <= overflow_q || push_drop;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_o      = data_q;
  assign rx_ack_o    = rx_ack_q;
  assign empty_o     = fifo_empty;
  assign ss_o        = ss_s;
  assign overflow_o  = overflow_q;
  assign frame_err_o = frame_err_q;

`ifdef SPI_RX_WORD_CNT_EN
  logic [15:0] word_cnt_q;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      word_cnt_q <= 16'd0;
    end else if (push_ok && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_q <= word_cnt_q + 16'd1;
    end else begin
      word_cnt_q <= word_cnt_q;
    end
  end

  assign word_cnt_o = word_cnt_q;
`endif

endmodule
